// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulate stage.
// Saturation build option: MAC_SATURATE_EN.
package mac_pkg;

  localparam int OP_W   = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  localparam logic [DATA_W-1:0] SAT_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    PUSH
  } state_e;

endpackage

// File: rtl/mac_mult_stage.sv
// Registered signed multiplier; ProdValid marks a product
// captured on the previous edge.
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int OpWidth = OP_W
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   EN,
  input  logic [OpWidth-1:0]     A,
  input  logic [OpWidth-1:0]     B,
  output logic [2*OpWidth-1:0]   Prod,
  output logic                   ProdValid
);

  localparam int PW = 2 * OpWidth;

  logic [PW-1:0] prod_q;
  logic          valid_q;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= EN;
      if (EN) begin
        prod_q <= PW'($signed(A)) * PW'($signed(B));
      end
    end
  end

  assign Prod      = prod_q;
  assign ProdValid = valid_q;

endmodule

// File: rtl/mac_accumulate.sv
// Multiply-accumulate job engine feeding the output FIFO.
// Define MAC_SATURATE_EN for clamping accumulation with Overflow.
module mac_accumulate
  import mac_pkg::*;
#(
  parameter int OpWidth    = OP_W,
  parameter int DataWidth  = DATA_W,
  parameter int CountWidth = CNT_W
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  Start,
  input  logic [CountWidth-1:0] Length,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [OpWidth-1:0]    A,
  input  logic [OpWidth-1:0]    B,
  input  logic                  Full,
  output logic                  Push,
  output logic [DataWidth-1:0]  DataOut,
  output logic                  Busy,
  output logic                  Overflow
);

  localparam int PW = 2 * OpWidth;

  state_e                state_q, state_d;
  logic [CountWidth-1:0] cnt_q, cnt_d;
  logic [DataWidth-1:0]  acc_q, acc_d;

  logic                  start_ok;
  logic                  accept;
  logic                  last;
  logic [PW-1:0]         prod;
  logic                  prod_vld;
  logic signed [DataWidth:0] sum;

  assign start_ok = (state_q == IDLE) & Start;
  assign accept   = InValid & InReady;
  assign last     = accept & (cnt_q == CountWidth'(1));

  mac_mult_stage #(
    .OpWidth(OpWidth)
  ) u_mult (
    .clk      (clk),
    .aclr     (aclr),
    .EN       (accept),
    .A        (A),
    .B        (B),
    .Prod     (prod),
    .ProdValid(prod_vld)
  );

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = (Length == '0) ? PUSH : ACC;
        end
      end
      ACC: begin
        if (last) state_d = DRAIN;
      end
      DRAIN: state_d = PUSH;
      PUSH: begin
        if (!Full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    InReady = 1'b0;
    Push    = 1'b0;
    Busy    = 1'b1;
    unique case (state_q)
      IDLE:    Busy    = 1'b0;
      ACC:     InReady = (cnt_q != '0);
      PUSH:    Push    = ~Full;
      default: ;
    endcase
  end

  // One guard bit so wrap and clamp see the true signed sum
  assign sum = (DataWidth+1)'($signed(acc_q))
             + (DataWidth+1)'($signed(prod));

`ifdef MAC_SATURATE_EN
  localparam logic [DataWidth-1:0] SatMax =
    {1'b0, {(DataWidth-1){1'b1}}};
  localparam logic [DataWidth-1:0] SatMin =
    {1'b1, {(DataWidth-1){1'b0}}};

  logic ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (start_ok) begin
      cnt_d = Length;
      acc_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (accept) cnt_d = cnt_q - CountWidth'(1);
      if (prod_vld) begin
        if (sum[DataWidth] != sum[DataWidth-1]) begin
          acc_d = sum[DataWidth] ? SatMin : SatMax;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[DataWidth-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Overflow = ovf_q;
`else
  logic sum_msb_unused;
  assign sum_msb_unused = sum[DataWidth];

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (start_ok) begin
      cnt_d = Length;
      acc_d = '0;
    end else begin
      if (accept) cnt_d = cnt_q - CountWidth'(1);
      if (prod_vld) acc_d = sum[DataWidth-1:0];
    end
  end

  assign Overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign DataOut = acc_q;

endmodule

// File: tb/tb_mac_accumulate.sv
// Self-checking bench for mac_accumulate with a queue-based
// arithmetic reference model and randomized handshakes.
module tb_mac_accumulate;

  localparam int OW = 16;
  localparam int DW = 32;
  localparam int CW = 8;

`ifdef MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          aclr = 1'b0;
  logic          Start = 1'b0;
  logic [CW-1:0] Length = '0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [OW-1:0] A = '0;
  logic [OW-1:0] B = '0;
  logic          Full = 1'b0;
  logic          Push;
  logic [DW-1:0] DataOut;
  logic          Busy;
  logic          Overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_accumulate #(
    .OpWidth(OW),
    .DataWidth(DW),
    .CountWidth(CW)
  ) dut (
    .clk(clk),
    .aclr(aclr),
    .Start(Start),
    .Length(Length),
    .InValid(InValid),
    .InReady(InReady),
    .A(A),
    .B(B),
    .Full(Full),
    .Push(Push),
    .DataOut(DataOut),
    .Busy(Busy),
    .Overflow(Overflow)
  );

  int opa[$];
  int opb[$];

  int            r_push_cnt;
  int            r_push_cyc;
  int            r_extra;
  int            r_busy_gap;
  int            r_ready_cyc;
  int            r_ready_after_last;
  logic [DW-1:0] r_data;
  logic          r_ovf;
  logic          r_busy_after;
  logic [DW-1:0] r_hold[$];

  // Reference: sum of products, wrapped or clamped after each add
  function automatic void model(output logic [DW-1:0] res,
                                output logic ovf);
    longint acc;
    acc = 0;
    ovf = 1'b0;
    foreach (opa[i]) begin
      acc += longint'(opa[i]) * longint'(opb[i]);
      if (SAT) begin
        if (acc > 64'sd2147483647) begin
          acc = 64'sd2147483647;
          ovf = 1'b1;
        end else if (acc < -64'sd2147483648) begin
          acc = -64'sd2147483648;
          ovf = 1'b1;
        end
      end else begin
        acc = longint'(int'(acc));
      end
    end
    res = acc[31:0];
  endfunction

  // Drives one job; caller is aligned 1 time unit after a rising edge
  task automatic run_job(input int len, input bit alt,
                         input int bub_pct, input int f_from,
                         input int f_to, input int f_pct,
                         input bit noise);
    int idx;
    int limit;
    int last_c;
    bit done;
    idx = 0;
    last_c = -1;
    done = 1'b0;
    r_push_cnt = 0;
    r_push_cyc = -1;
    r_extra = 0;
    r_busy_gap = 0;
    r_ready_cyc = 0;
    r_ready_after_last = -1;
    r_data = '0;
    r_ovf = 1'b0;
    r_hold.delete();
    limit = 4 * len + f_to + 60;
    Start = 1'b1;
    Length = CW'(len);
    InValid = noise ? 1'($urandom) : 1'b0;
    Full = 1'b0;
    #1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    for (int c = 1; c <= limit && !done; c++) begin
      if (noise) begin
        Start = 1'($urandom);
        Length = CW'($urandom);
      end
      if (idx < len) begin
        InValid = alt ? (c % 2 == 1)
                      : ($urandom_range(99) >= bub_pct);
        A = OW'(opa[idx]);
        B = OW'(opb[idx]);
      end else begin
        InValid = noise ? 1'($urandom) : 1'b0;
        A = OW'($urandom);
        B = OW'($urandom);
      end
      Full = (c >= f_from && c <= f_to)
          || ($urandom_range(99) < f_pct);
      #1;
      if (last_c >= 0 && c == last_c + 1) r_ready_after_last = InReady;
      if (InReady) r_ready_cyc++;
      if (!Busy) r_busy_gap++;
      if (c >= f_from && c <= f_to) r_hold.push_back(DataOut);
      if (InValid && InReady) begin
        if (idx < len) begin
          idx++;
          if (idx == len) last_c = c;
        end else begin
          r_extra++;
        end
      end
      if (Push) begin
        r_push_cnt++;
        r_push_cyc = c;
        r_data = DataOut;
        r_ovf = Overflow;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    Start = 1'b0;
    InValid = 1'b0;
    Full = 1'b0;
    #1;
    r_busy_after = Busy;
    if (Push) r_push_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aclr = 1'b0;
    #3;
    checks++;
    if (InReady !== 1'b0) begin
      failures++;
      $display("FAIL reset_inready: got %b want 0", InReady);
    end
    checks++;
    if (Push !== 1'b0) begin
      failures++;
      $display("FAIL reset_push: got %b want 0", Push);
    end
    checks++;
    if (DataOut !== '0) begin
      failures++;
      $display("FAIL reset_dataout: got %h want 0", DataOut);
    end
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b want 0", Busy);
    end
    checks++;
    if (Overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_overflow: got %b want 0", Overflow);
    end
    @(posedge clk);
    @(negedge clk);
    aclr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    opa = '{1, 2, 3, 4};
    opb = '{5, 6, 7, 8};
    run_job(4, 1'b0, 0, 0, -1, 0, 1'b0);
    checks++;
    if (r_push_cnt != 1) begin
      failures++;
      $display("FAIL basic_push_count: got %0d want 1", r_push_cnt);
    end
    checks++;
    if (r_push_cyc != 6) begin
      failures++;
      $display("FAIL basic_push_cycle: got %0d want 6", r_push_cyc);
    end
    checks++;
    if (r_data !== 32'd70) begin
      failures++;
      $display("FAIL basic_data: got %0d want 70", r_data);
    end
    checks++;
    if (r_busy_after !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_after: got %b want 0", r_busy_after);
    end
    checks++;
    if (r_ready_cyc != 4) begin
      failures++;
      $display("FAIL basic_ready_cycles: got %0d want 4", r_ready_cyc);
    end
  endtask

  task automatic test_full();
    int bad;
    opa = '{1, 2, 3, 4};
    opb = '{5, 6, 7, 8};
    run_job(4, 1'b0, 0, 6, 10, 0, 1'b0);
    checks++;
    if (r_push_cyc != 11 || r_push_cnt != 1) begin
      failures++;
      $display("FAIL full_push: got cycle %0d count %0d want 11 1",
               r_push_cyc, r_push_cnt);
    end
    checks++;
    if (r_data !== 32'd70) begin
      failures++;
      $display("FAIL full_data: got %0d want 70", r_data);
    end
    bad = 0;
    foreach (r_hold[i]) if (r_hold[i] !== 32'd70) bad++;
    checks++;
    if (bad != 0 || r_hold.size() != 5) begin
      failures++;
      $display("FAIL full_hold: got %0d bad of %0d want 0 of 5",
               bad, r_hold.size());
    end
  endtask

  task automatic test_len0();
    opa.delete();
    opb.delete();
    run_job(0, 1'b0, 0, 0, -1, 0, 1'b0);
    checks++;
    if (r_push_cyc != 1 || r_push_cnt != 1) begin
      failures++;
      $display("FAIL len0_push: got cycle %0d count %0d want 1 1",
               r_push_cyc, r_push_cnt);
    end
    checks++;
    if (r_data !== '0) begin
      failures++;
      $display("FAIL len0_data: got %h want 0", r_data);
    end
    checks++;
    if (r_ready_cyc != 0) begin
      failures++;
      $display("FAIL len0_ready: got %0d want 0", r_ready_cyc);
    end
  endtask

  task automatic test_bubbles();
    opa = '{-3, -3, -3};
    opb = '{7, 7, 7};
    run_job(3, 1'b1, 0, 0, -1, 0, 1'b0);
    checks++;
    if (r_ready_after_last != 0) begin
      failures++;
      $display("FAIL bubble_ready_drop: got %0d want 0",
               r_ready_after_last);
    end
    checks++;
    if (r_push_cyc != 7 || r_push_cnt != 1) begin
      failures++;
      $display("FAIL bubble_push: got cycle %0d count %0d want 7 1",
               r_push_cyc, r_push_cnt);
    end
    checks++;
    if (r_data !== 32'hFFFFFFC1) begin
      failures++;
      $display("FAIL bubble_data: got %h want ffffffc1", r_data);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_d;
    logic          exp_o;
    exp_d = SAT ? 32'h7FFFFFFF : 32'hC0000000;
    exp_o = SAT;
    opa = '{-32768, -32768, -32768};
    opb = '{-32768, -32768, -32768};
    run_job(3, 1'b0, 0, 0, -1, 0, 1'b0);
    checks++;
    if (r_data !== exp_d) begin
      failures++;
      $display("FAIL ovf_data: got %h want %h", r_data, exp_d);
    end
    checks++;
    if (r_ovf !== exp_o) begin
      failures++;
      $display("FAIL ovf_flag: got %b want %b", r_ovf, exp_o);
    end
    checks++;
    if (Overflow !== exp_o) begin
      failures++;
      $display("FAIL ovf_sticky: got %b want %b", Overflow, exp_o);
    end
    opa = '{1};
    opb = '{1};
    run_job(1, 1'b0, 0, 0, -1, 0, 1'b0);
    checks++;
    if (r_ovf !== 1'b0 || r_data !== 32'd1) begin
      failures++;
      $display("FAIL ovf_clear: got ovf %b data %h want 0 1",
               r_ovf, r_data);
    end
  endtask

  task automatic test_reset_mid_job();
    int pushes;
    pushes = 0;
    Start = 1'b1;
    Length = CW'(4);
    #1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    InValid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      A = OW'(k + 1);
      B = OW'(k + 5);
      #1;
      if (Push) pushes++;
      @(posedge clk);
      #1;
    end
    aclr = 1'b0;
    #1;
    checks++;
    if ({InReady, Push, Busy, Overflow} !== 4'b0) begin
      failures++;
      $display("FAIL midrst_flags: got %b want 0000",
               {InReady, Push, Busy, Overflow});
    end
    checks++;
    if (DataOut !== '0) begin
      failures++;
      $display("FAIL midrst_data: got %h want 0", DataOut);
    end
    @(posedge clk);
    #1;
    if (Push) pushes++;
    InValid = 1'b0;
    aclr = 1'b1;
    opa = '{2};
    opb = '{3};
    run_job(1, 1'b0, 0, 0, -1, 0, 1'b0);
    checks++;
    if (pushes != 0) begin
      failures++;
      $display("FAIL midrst_nopush: got %0d want 0", pushes);
    end
    checks++;
    if (r_data !== 32'd6 || r_push_cyc != 3) begin
      failures++;
      $display("FAIL midrst_next: got data %0d cycle %0d want 6 3",
               r_data, r_push_cyc);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0]    exp_d;
    logic             exp_o;
    logic signed [15:0] t;
    int               len;
    for (int j = 0; j < 25; j++) begin
      len = $urandom_range(12);
      opa.delete();
      opb.delete();
      for (int k = 0; k < len; k++) begin
        t = 16'($urandom);
        opa.push_back(int'(t));
        t = 16'($urandom);
        opb.push_back(int'(t));
      end
      model(exp_d, exp_o);
      run_job(len, 1'b0, 30, 0, -1, 30, 1'b1);
      checks++;
      if (r_push_cnt != 1 || r_data !== exp_d) begin
        failures++;
        $display("FAIL rand_data[%0d]: got %h x%0d want %h x1",
                 j, r_data, r_push_cnt, exp_d);
      end
      checks++;
      if (r_ovf !== exp_o) begin
        failures++;
        $display("FAIL rand_ovf[%0d]: got %b want %b", j, r_ovf, exp_o);
      end
      checks++;
      if (r_extra != 0 || r_busy_gap != 0 || r_busy_after !== 1'b0) begin
        failures++;
        $display("FAIL rand_proto[%0d]: got extra %0d gap %0d busy %b want 0 0 0",
                 j, r_extra, r_busy_gap, r_busy_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_len0();
    test_bubbles();
    test_overflow();
    test_reset_mid_job();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_accumulate.md
# mac_accumulate

Upstream compute stage of the MAC output path. It accepts a stream of signed operand pairs, multiplies each pair, and accumulates `Length` products into one DataWidth-bit result. It then writes that result into the output-data FIFO with a single-cycle `Push`, stalling while the FIFO reports `Full`. One accumulation job runs at a time. A job is launched by a `Start` pulse.

## Interface
- `OpWidth`, 16, width of each signed operand
- `DataWidth`, 32, result width; matches the output FIFO `DataWidth`
- `CountWidth`, 8, width of `Length`
- `clk`  in  1  single clock; all state changes on rising edge
- `aclr`  in  1  asynchronous, active-low reset; assertion takes effect immediately, release is synchronous to `clk`
- `Start`  in  1  job launch pulse; sampled only in IDLE
- `Length`  in  CountWidth  number of products in the job; latched with `Start`
- `InValid`  in  1  operand pair valid
- `InReady`  out  1  stage can accept an operand pair
- `A`, `B`  in  OpWidth each  signed two's-complement operands
- `Full`  in  1  output FIFO full flag
- `Push`  out  1  FIFO write strobe
- `DataOut`  out  DataWidth  result; drives FIFO `DataIn`
- `Busy`  out  1  job in progress (any state except IDLE)
- `Overflow`  out  1  result saturated; sticky until the next accepted `Start`

## Operation
- States: IDLE, ACC, DRAIN, PUSH.
- IDLE:
  - `Start`=1 latches `Length` into the remaining-count register and clears the accumulator, the product-valid bit and `Overflow`.
  - Next state is ACC, or PUSH directly if `Length`=0.
- ACC:
  - `InReady`=1 while remaining count > 0.
  - A pair is accepted when `InValid & InReady`. On acceptance, A*B (2*OpWidth bits, signed) is registered, the product-valid bit is set and the remaining count is decremented.
  - After the last pair is accepted, the next state is DRAIN.
- Product stage: a registered product with its valid bit set is sign-extended and added to the accumulator on the following edge.
- DRAIN: one cycle. The last product is added, then the next state is PUSH.
- PUSH:
  - `DataOut` = accumulator.
  - `Push` = ~`Full`, combinational.
  - The edge with `Push`=1 completes the job and returns to IDLE.
  - While `Full`=1, the stage holds in PUSH with `Push`=0 and `DataOut` stable.
- `Start` outside IDLE is ignored. `InValid` outside ACC, or with remaining count = 0, is ignored and no pair is consumed.
- Arithmetic:
  - Sum is computed at DataWidth+1 bits.
  - Default: the result wraps modulo 2^DataWidth and `Overflow` stays 0.
- Reset values: `InReady`=0, `Push`=0, `DataOut`=0, `Busy`=0, `Overflow`=0. State is IDLE, and count and accumulator are 0.
- Reset mid-job: the job is discarded, no `Push` is issued, and the stage is ready for `Start` on the first cycle after release.

## Timing
- `Start` accepted at cycle 0 with `Length`=N>0 and `InValid` held high:
  - Pairs are accepted in cycles 1..N.
  - DRAIN is cycle N+1.
  - PUSH is cycle N+2; `Push` is high in cycle N+2 if `Full`=0.
- `InValid` bubbles extend ACC one cycle per bubble.
- `Length`=0: PUSH in cycle 1 with `DataOut`=0.
- Minimum job-to-job interval is N+3 cycles, since IDLE is required between jobs.
- `Full` rising in the same cycle as PUSH entry: `Push` is 0 that cycle, with no lost or duplicated write.

## Configuration
- `MAC_SATURATE_EN` defined:
  - On signed overflow of an add, the accumulator clamps to 0x7FFF…F or 0x800…0 (DataWidth bits) and `Overflow` is set.
  - Later adds continue from the clamped value.
- Not defined:
  - Two's-complement wrap.
  - `Overflow` is tied to 0.

## Structure
- Shared package `mac_pkg`:
  - state enum (IDLE, ACC, DRAIN, PUSH)
  - default `OpWidth`/`DataWidth`/`CountWidth` constants
  - saturation limit constants
- Sub-module `mac_mult_stage`: registered signed multiplier with a valid bit, with `clk`/`aclr`/`EN`/`A`/`B` inputs and `Prod`/`ProdValid` outputs.
- The FSM, counter and accumulator live in the top module.

## Test plan
- `Length`=4, A={1,2,3,4}, B={5,6,7,8}, `Full`=0, `InValid` continuous -> one `Push` pulse in cycle 6, `DataOut`=70, `Busy` low in cycle 7.
- Same job with `Full`=1 for cycles 6-10 -> `Push`=0 through cycle 10, `Push`=1 in cycle 11, `DataOut`=70 held throughout.
- `Length`=0 -> `Push` in cycle 1, `DataOut`=0, `InReady` never high.
- `Length`=3, A=-3, B=7 with one `InValid` bubble between each pair:
  - `InReady` drops after the third acceptance.
  - `DataOut`=0xFFFFFFC1 (-63).
- `Length`=3, A=B=-32768:
  - With `MAC_SATURATE_EN`: `DataOut`=0x7FFFFFFF, `Overflow`=1.
  - Without it: `DataOut`=0xC0000000, `Overflow`=0.
  - A new `Start` clears `Overflow`.
- `aclr` pulsed low during ACC (after 2 of 4 pairs):
  - All outputs return to reset values immediately.
  - No `Push` occurs.
  - A subsequent 1-pair job (2×3) pushes 6.
